div_unit_32bit: RTL and testbench

Iterative restoring divider for the MIPS DIV/DIVU instructions. Sits downstream of the execute-stage operand muxes and feeds the HI/LO register pair. Each iteration does one trial subtraction through the team's 32-bit subtractor, SUB_32bit, and uses its borrow output to choose the quotient bit. A start/busy/done handshake lets the pipeline stall while a divide is in flight.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_unit_32bit_if.sv | 25 ++
 rtl/SUB_32bit.sv | 18 +
 rtl/div_unit_32bit.sv | 162 ++++++++++++++++
 tb/tb_div_unit_32bit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  // Two's-complement negation, wrapping mod 2^DIV_WIDTH.
  function automatic logic [DIV_WIDTH-1:0] div_neg(input logic [DIV_WIDTH-1:0] v);
    return (~v) + DIV_WIDTH'(1);
  endfunction

  function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? div_neg(v) : v;
  endfunction

endpackage

// File: rtl/div_unit_32bit_if.sv
// Request/result bundle between the execute stage and the divider.
interface div_unit_32bit_if;
  import div_pkg::*;

  logic                 start;
  logic                 is_signed;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/SUB_32bit.sv
// 32-bit subtractor: diff = a - b - cin, with borrow-out and signed overflow.
module SUB_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] diff,
  output logic        borrow,
  output logic        ovf
);

  logic [32:0] full_c;

  assign full_c = {1'b0, a} - {1'b0, b} - 33'(cin);
  assign diff   = full_c[31:0];
  assign borrow = full_c[32];
  assign ovf    = (a[31] ^ b[31]) & (diff[31] ^ a[31]);

endmodule

// File: rtl/div_unit_32bit.sv
// Iterative restoring divider for MIPS DIV/DIVU, one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour is_signed; otherwise every divide is unsigned.
module div_unit_32bit
  import div_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  div_unit_32bit_if.slave  bus
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] prem_q, prem_d;
  logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic [DIV_WIDTH-1:0] quo_q, quo_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;
`ifdef DIV_SIGNED_EN
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
`else
  logic                 signed_unused;
  assign signed_unused = bus.is_signed;
`endif

  logic                 shift_top_c;
  logic [DIV_WIDTH-1:0] shift_low_c;
  logic [DIV_WIDTH-1:0] trial_c;
  logic                 borrow_c;
  logic                 sub_ovf_unused;

  assign shift_top_c = prem_q[DIV_WIDTH-1];
  assign shift_low_c = {prem_q[DIV_WIDTH-2:0], dvd_q[DIV_WIDTH-1]};

  SUB_32bit u_sub (
    .a      (shift_low_c),
    .b      (dvs_q),
    .cin    (1'b0),
    .diff   (trial_c),
    .borrow (borrow_c),
    .ovf    (sub_ovf_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prem_q    <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = DIV_ZERO_QUOTIENT;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            prem_d  = '0;
            dvd_d   = bus.dividend;
            dvs_d   = bus.divisor;
`ifdef DIV_SIGNED_EN
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            if (bus.is_signed) begin
              dvd_d     = div_abs(bus.dividend);
              dvs_d     = div_abs(bus.divisor);
              neg_quo_d = bus.dividend[DIV_WIDTH-1] ^ bus.divisor[DIV_WIDTH-1];
              neg_rem_d = bus.dividend[DIV_WIDTH-1];
            end
`endif
          end
        end
      end
      CALC: begin
        // Shifted-out MSB set means the shifted value exceeds any divisor.
        if (shift_top_c || !borrow_c) begin
          prem_d = trial_c;
          dvd_d  = {dvd_q[DIV_WIDTH-2:0], 1'b1};
        end else begin
          prem_d = shift_low_c;
          dvd_d  = {dvd_q[DIV_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(DIV_WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        dz_d    = 1'b0;
`ifdef DIV_SIGNED_EN
        quo_d   = neg_quo_q ? div_neg(dvd_q) : dvd_q;
        rem_d   = neg_rem_q ? div_neg(prem_q) : prem_q;
`else
        quo_d   = dvd_q;
        rem_d   = prem_q;
`endif
      end
      DONE: begin
        // Stay until the done pulse has been issued (one extra cycle on /0).
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX) || ((state_q == DONE) && !done_q);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_div_unit_32bit.sv
// Directed self-checking bench for div_unit_32bit (both DIV_SIGNED_EN builds).
module tb_div_unit_32bit;
  import div_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  div_unit_32bit_if bus_if ();

  div_unit_32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_SIGNED_EN
  localparam logic [31:0] EXP_NEG7_Q  = 32'hFFFF_FFFD;
  localparam logic [31:0] EXP_NEG7_R  = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_MIN_Q   = 32'h8000_0000;
  localparam logic [31:0] EXP_MIN_R   = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_NEG7_Q  = 32'h7FFF_FFFC;
  localparam logic [31:0] EXP_NEG7_R  = 32'h0000_0001;
  localparam logic [31:0] EXP_MIN_Q   = 32'h0000_0000;
  localparam logic [31:0] EXP_MIN_R   = 32'h8000_0000;
`endif

  // Present a request for one edge; returns #1 after the accepting edge.
  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus_if.start     = 1'b1;
    bus_if.is_signed = sgn;
    bus_if.dividend  = a;
    bus_if.divisor   = b;
    @(posedge clk); #1;
    bus_if.start     = 1'b0;
  endtask

  // Edges until done is seen (-1 on timeout); busy_ok clears if busy ever dropped.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
      if (bus_if.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.start = 1'b0; bus_if.is_signed = 1'b0;
    bus_if.dividend = '0; bus_if.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus_if.done); end
    checks++; if (bus_if.quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient: got %h expected 0", bus_if.quotient); end
    checks++; if (bus_if.remainder !== 32'h0) begin errors++; $display("FAIL reset_remainder: got %h expected 0", bus_if.remainder); end
    checks++; if (bus_if.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", bus_if.div_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic();
    int lat; logic bok;
    start_div(1'b0, 32'd100, 32'd7);
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", bus_if.busy); end
    wait_done(lat, bok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL basic_latency: got %0d expected 33", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy_held: got %b expected 1", bok); end
    checks++; if (bus_if.quotient !== 32'd14) begin errors++; $display("FAIL basic_quotient: got %0d expected 14", bus_if.quotient); end
    checks++; if (bus_if.remainder !== 32'd2) begin errors++; $display("FAIL basic_remainder: got %0d expected 2", bus_if.remainder); end
    checks++; if (bus_if.div_zero !== 1'b0) begin errors++; $display("FAIL basic_div_zero: got %b expected 0", bus_if.div_zero); end
    @(posedge clk); #1;
    checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bus_if.done); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.quotient !== 32'd14) begin errors++; $display("FAIL basic_hold: got %0d expected 14", bus_if.quotient); end
  endtask

  task automatic test_signed();
    int lat; logic bok;
    start_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL neg7_latency: got %0d expected 33", lat); end
    checks++; if (bus_if.quotient !== EXP_NEG7_Q) begin errors++; $display("FAIL neg7_quotient: got %h expected %h", bus_if.quotient, EXP_NEG7_Q); end
    checks++; if (bus_if.remainder !== EXP_NEG7_R) begin errors++; $display("FAIL neg7_remainder: got %h expected %h", bus_if.remainder, EXP_NEG7_R); end
    @(posedge clk); #1;
    start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bok);
    checks++; if (bus_if.quotient !== EXP_MIN_Q) begin errors++; $display("FAIL min_quotient: got %h expected %h", bus_if.quotient, EXP_MIN_Q); end
    checks++; if (bus_if.remainder !== EXP_MIN_R) begin errors++; $display("FAIL min_remainder: got %h expected %h", bus_if.remainder, EXP_MIN_R); end
    @(posedge clk); #1;
    start_div(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(lat, bok);
    checks++; if (bus_if.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_quotient: got %h expected ffffffff", bus_if.quotient); end
    checks++; if (bus_if.remainder !== 32'h0) begin errors++; $display("FAIL max_remainder: got %h expected 0", bus_if.remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat; logic bok;
    start_div(1'b0, 32'd1234, 32'd0);
    wait_done(lat, bok);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    checks++; if (bus_if.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quotient: got %h expected ffffffff", bus_if.quotient); end
    checks++; if (bus_if.remainder !== 32'd1234) begin errors++; $display("FAIL dz_remainder: got %0d expected 1234", bus_if.remainder); end
    checks++; if (bus_if.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", bus_if.div_zero); end
    @(posedge clk); #1;
    checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin errors++; $display("FAIL dz_idle: got busy %b done %b expected 0 0", bus_if.busy, bus_if.done); end
  endtask

  // Starts in the earliest legal cycle after a divide-by-zero result.
  task automatic test_back_to_back();
    int lat; logic bok;
    start_div(1'b0, 32'd100, 32'd7);
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", bus_if.busy); end
    checks++; if (bus_if.div_zero !== 1'b1 || bus_if.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hold: got dz %b q %h expected 1 ffffffff", bus_if.div_zero, bus_if.quotient); end
    wait_done(lat, bok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
    checks++; if (bus_if.quotient !== 32'd14 || bus_if.remainder !== 32'd2 || bus_if.div_zero !== 1'b0) begin errors++; $display("FAIL b2b_result: got q %0d r %0d dz %b expected 14 2 0", bus_if.quotient, bus_if.remainder, bus_if.div_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start();
    int lat; logic bok;
    start_div(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus_if.start = 1'b1; bus_if.dividend = 32'd50; bus_if.divisor = 32'd5;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    wait_done(lat, bok);
    checks++; if (lat !== 23) begin errors++; $display("FAIL ign_latency: got %0d expected 23", lat); end
    checks++; if (bus_if.quotient !== 32'd14 || bus_if.remainder !== 32'd2) begin errors++; $display("FAIL ign_result: got q %0d r %0d expected 14 2", bus_if.quotient, bus_if.remainder); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL ign_no_queue: got busy %b expected 0", bus_if.busy); end
  endtask

  task automatic test_reset_mid();
    int lat; logic bok;
    start_div(1'b0, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got busy %b done %b expected 0 0", bus_if.busy, bus_if.done); end
    checks++; if (bus_if.quotient !== 32'h0 || bus_if.remainder !== 32'h0 || bus_if.div_zero !== 1'b0) begin errors++; $display("FAIL rst_mid_result: got q %h r %h dz %b expected 0 0 0", bus_if.quotient, bus_if.remainder, bus_if.div_zero); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_div(1'b0, 32'd9, 32'd3);
    wait_done(lat, bok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL rst_mid_latency: got %0d expected 33", lat); end
    checks++; if (bus_if.quotient !== 32'd3 || bus_if.remainder !== 32'd0) begin errors++; $display("FAIL rst_mid_fresh: got q %0d r %0d expected 3 0", bus_if.quotient, bus_if.remainder); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
